// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem requests,
// stall hold, redirect with in-flight fetch discard, misaligned-target fault.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        FAULT
    } state_t;

    state_t state, state_n;

    logic [31:0] pc_reg;
    logic [31:0] req_pc;
    logic [31:0] buf_data;
    logic [31:0] present_data;
    logic        fire;
    logic        redir;
    logic        misalign;
    logic        present;

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc_reg;
    assign fire           = imem_req_valid & imem_req_ready;
    assign redir          = redirect & (state != FAULT);
    assign misalign       = |redirect_pc[1:0];

    assign present = !redir && !stall &&
                     ((state == WAIT && imem_rsp_valid) ||
                      (state == HOLD));
    assign present_data = (state == HOLD) ? buf_data : imem_rsp_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  state_n = REQ;
            REQ:   if (fire) state_n = WAIT;
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_n = stall ? HOLD : REQ;
                end
            end
            HOLD:  if (!stall) state_n = REQ;
            DRAIN: if (imem_rsp_valid) state_n = REQ;
            FAULT: state_n = FAULT;
            default: state_n = IDLE;
        endcase
        // Redirect wins; DRAIN only if a response is still owed to us.
        if (redir) begin
            if (misalign) begin
                state_n = FAULT;
            end else if (state == DRAIN) begin
                state_n = imem_rsp_valid ? REQ : DRAIN;
            end else if ((state == WAIT && !imem_rsp_valid) || fire) begin
                state_n = DRAIN;
            end else begin
                state_n = REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg      <= RESET_PC;
            req_pc      <= RESET_PC;
            buf_data    <= NOP_INSTR;
            pc_out      <= 32'h0;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            if (fire) begin
                req_pc <= pc_reg;
            end
            if (state == WAIT && imem_rsp_valid && stall && !redir) begin
                buf_data <= imem_rsp_data;
            end
            if (redir) begin
                pc_reg      <= redirect_pc;
                buf_data    <= NOP_INSTR;
                instr_out   <= NOP_INSTR;
                instr_valid <= 1'b0;
                if (misalign) begin
                    fetch_fault <= 1'b1;
                end
            end else if (stall) begin
                instr_valid <= instr_valid;
            end else if (present) begin
                pc_out      <= req_pc;
                instr_out   <= present_data;
                instr_valid <= 1'b1;
                pc_reg      <= req_pc + 32'd4;
            end else begin
                instr_out   <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: scoreboard queues for requests and
// presented instructions, checked by a negedge monitor.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        fetch_fault;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] req_q[$];
    logic [63:0] ins_q[$];

    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          cnt = 0;
    int          lat = 1;
    logic        prev_stall = 1'b0;
    logic [63:0] exp_ins;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(logic [31:0] a);
        req_q.push_back(a);
    endtask

    task automatic push_ins(logic [31:0] pc);
        ins_q.push_back({pc, ~pc});
    endtask

    // memory: answers ~addr, lat cycles after fire
    initial forever begin
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~pend_addr;
                pend = 1'b0;
            end
        end
    end

    // monitor
    initial forever begin
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            chk("single_outstanding", {31'b0, pend}, 32'h0);
            pend      = 1'b1;
            pend_addr = imem_req_addr;
            cnt       = lat;
            if (req_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL req_unexpected: got %h want none",
                         imem_req_addr);
            end else begin
                chk("req_addr", imem_req_addr, req_q.pop_front());
            end
        end
        if (instr_valid && !prev_stall) begin
            if (ins_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL instr_unexpected: got pc %h want none",
                         pc_out);
            end else begin
                exp_ins = ins_q.pop_front();
                chk("pc_out", pc_out, exp_ins[63:32]);
                chk("instr_out", instr_out, exp_ins[31:0]);
            end
        end
        if (!instr_valid) begin
            chk("bubble_nop", instr_out, NOP);
        end
        prev_stall = stall;
    end

    initial begin
        logic [6:0] vpat;
        vpat = 7'b1010100;

        repeat (3) cyc();
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instr_out", instr_out, NOP);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'h0);

        push_req(32'h0);
        push_req(32'h4);
        push_req(32'h8);
        push_ins(32'h0);
        push_ins(32'h4);
        push_ins(32'h8);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk("valid_pulse", {31'b0, instr_valid}, {31'b0, vpat[k-1]});
        end

        // back-pressure on request at 0xC
        imem_req_ready = 1'b0;
        push_req(32'hC);
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_valid", {31'b0, imem_req_valid}, 32'h1);
            chk("bp_req_addr", imem_req_addr, 32'hC);
            cyc();
        end
        imem_req_ready = 1'b1;
        push_ins(32'hC);

        // response lands under stall
        cyc();
        stall = 1'b1;
        cyc();
        chk("stall_pc_hold", pc_out, 32'h8);
        chk("stall_valid_hold", {31'b0, instr_valid}, 32'h0);
        chk("hold_no_req", {31'b0, imem_req_valid}, 32'h0);
        cyc();
        chk("stall_pc_hold2", pc_out, 32'h8);
        chk("hold_no_req2", {31'b0, imem_req_valid}, 32'h0);
        stall = 1'b0;
        push_req(32'h10);

        // redirect while a slow fetch is outstanding
        cyc();
        lat = 3;
        cyc();
        lat = 1;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        push_req(32'h100);
        push_req(32'h104);
        push_req(32'h108);
        push_ins(32'h100);
        push_ins(32'h104);
        cyc();
        redirect = 1'b0;
        cyc();
        cyc();
        chk("late_rsp_dropped", {31'b0, instr_valid}, 32'h0);
        repeat (5) cyc();

        // redirect coincident with response, PC wrap
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        push_req(32'hFFFF_FFFC);
        push_req(32'h0);
        push_req(32'h4);
        push_ins(32'hFFFF_FFFC);
        push_ins(32'h0);
        cyc();
        redirect = 1'b0;
        repeat (5) cyc();

        // misaligned target
        chk("no_fault_yet", {31'b0, fetch_fault}, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h102;
        cyc();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fault_set", {31'b0, fetch_fault}, 32'h1);
            chk("fault_no_req", {31'b0, imem_req_valid}, 32'h0);
            chk("fault_no_valid", {31'b0, instr_valid}, 32'h0);
            cyc();
        end

        rst = 1'b1;
        cyc();
        chk("fault_cleared", {31'b0, fetch_fault}, 32'h0);
        chk("rst2_pc_out", pc_out, 32'h0);
        push_req(32'h0);
        push_ins(32'h0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (req_q.size() == 0) imem_req_ready = 1'b0;
            if (req_q.size() == 0 && ins_q.size() == 0) break;
        end
        repeat (3) cyc();
        chk("queues_drained", req_q.size() + ins_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
